// File: rtl/instr_pkg.sv
// Shared encodings for the instruction-immediate packer: ImmSrc formats,
// error codes, FSM states and a sign-extension range helper.
package instr_pkg;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_RANGE    = 2'b01;
  localparam logic [1:0] ERR_MISALIGN = 2'b10;

  typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, ERROR} packer_state_t;

  // True when imm[31:msb] are all equal, i.e. imm survives truncation to msb+1 bits.
  function automatic logic sext_fits(input logic [31:0] imm, input int unsigned msb);
    logic signed [31:0] s;
    s = $signed(imm) >>> msb;
    return (s == '0) || (s == '1);
  endfunction

endpackage

// File: rtl/instr_imm_packer_if.sv
// Upstream instruction handshake: decoded fields plus immediate, valid/ready/last.
interface instr_imm_packer_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [2:0]  ImmSrc;
  logic [31:0] imm;

  modport master (
    output in_valid, in_last, opcode, rd, rs1, rs2, funct3, funct7, ImmSrc, imm,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_last, opcode, rd, rs1, rs2, funct3, funct7, ImmSrc, imm,
    output in_ready
  );
endinterface

// File: rtl/instr_imm_packer_pack.sv
// Combinational packer: places the immediate into the selected instruction
// format and reports whether it is representable there.
module instr_imm_pack
  import instr_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [2:0]  ImmSrc,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        legal,
  output logic [1:0]  err_code
);

  logic range_ok;
  logic misalign;

  always_comb begin
    word     = '0;
    range_ok = 1'b1;
    misalign = 1'b0;
    case (ImmSrc)
      IMM_I: begin
        word     = {imm[11:0], rs1, funct3, rd, opcode};
        range_ok = sext_fits(imm, 11);
      end
      IMM_S: begin
        word     = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        range_ok = sext_fits(imm, 11);
      end
      IMM_B: begin
        word     = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        range_ok = sext_fits(imm, 12);
        misalign = imm[0];
      end
      IMM_U: begin
        word     = {imm[31:12], rd, opcode};
        range_ok = (imm[11:0] == '0);
      end
      IMM_J: begin
        word     = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        range_ok = sext_fits(imm, 20);
        misalign = imm[0];
      end
      default: word = {funct7, rs2, rs1, funct3, rd, opcode};
    endcase

    legal = range_ok && !misalign;
    if (misalign)       err_code = ERR_MISALIGN;
    else if (!range_ok) err_code = ERR_RANGE;
    else                err_code = ERR_NONE;
  end

endmodule

// File: rtl/instr_imm_packer.sv
// Loads packed instructions into byte-addressed instruction memory,
// little-endian, one byte per cycle, under a start/last session protocol.
module instr_imm_packer
  import instr_pkg::*;
#(
  parameter int unsigned MEM_ADDR_WIDTH = 8,
  parameter int unsigned COUNT_WIDTH    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [MEM_ADDR_WIDTH-1:0] base_addr,
  instr_imm_packer_if.slave         in_if,
  output logic                      mem_we,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]                mem_wdata,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [1:0]                err_code,
  output logic [COUNT_WIDTH-1:0]    instr_count
);

  packer_state_t             state_q, state_d;
  logic [MEM_ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0]                beat_q, beat_d;
  logic [31:0]               word_q, word_d;
  logic                      last_q, last_d;
  logic [COUNT_WIDTH-1:0]    count_q, count_d;
  logic                      err_q, err_d;
  logic [1:0]                err_code_q, err_code_d;
  logic                      done_q, done_d;

  logic [31:0] pk_word;
  logic        pk_legal;
  logic [1:0]  pk_err_code;
  logic [31:0] word_shift;

  instr_imm_pack u_pack (
    .opcode   (in_if.opcode),
    .rd       (in_if.rd),
    .rs1      (in_if.rs1),
    .rs2      (in_if.rs2),
    .funct3   (in_if.funct3),
    .funct7   (in_if.funct7),
    .ImmSrc   (in_if.ImmSrc),
    .imm      (in_if.imm),
    .word     (pk_word),
    .legal    (pk_legal),
    .err_code (pk_err_code)
  );

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    beat_d     = beat_q;
    word_d     = word_q;
    last_d     = last_q;
    count_d    = count_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE, ERROR: begin
        if (start) begin
          wr_ptr_d   = base_addr;
          count_d    = '0;
          err_d      = 1'b0;
          err_code_d = ERR_NONE;
          state_d    = ACCEPT;
        end
      end
      ACCEPT: begin
        if (in_if.in_valid) begin
          if (pk_legal) begin
            word_d  = pk_word;
            last_d  = in_if.in_last;
            beat_d  = '0;
            state_d = WRITE;
          end else begin
            err_d      = 1'b1;
            err_code_d = pk_err_code;
            state_d    = ERROR;
          end
        end
      end
      WRITE: begin
        wr_ptr_d = wr_ptr_q + MEM_ADDR_WIDTH'(1);
        beat_d   = beat_q + 2'd1;
        if (beat_q == 2'd3) begin
          count_d = count_q + COUNT_WIDTH'(1);
          if (last_q) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = ACCEPT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      beat_q     <= '0;
      word_q     <= '0;
      last_q     <= 1'b0;
      count_q    <= '0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      beat_q     <= beat_d;
      word_q     <= word_d;
      last_q     <= last_d;
      count_q    <= count_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      done_q     <= done_d;
    end
  end

  // Memory bus is forced to zero outside WRITE so idle cycles present a clean bus.
  always_comb begin
    word_shift = word_q >> {beat_q, 3'b000};
    mem_we     = (state_q == WRITE);
    mem_addr   = mem_we ? wr_ptr_q : '0;
    mem_wdata  = mem_we ? word_shift[7:0] : '0;
  end

  assign in_if.in_ready = (state_q == ACCEPT);
  assign busy           = (state_q == ACCEPT) || (state_q == WRITE);
  assign done           = done_q;
  assign err            = err_q;
  assign err_code       = err_code_q;
  assign instr_count    = count_q;

endmodule

// File: tb/tb_instr_imm_packer.sv
// Scoreboard bench for instr_imm_packer: expected bytes are queued when an
// instruction is offered and matched against every observed memory write.
module tb_instr_imm_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  base_addr = '0;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;
  logic [15:0] instr_count;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] mem [256];
  logic [7:0] exp_addr = '0;
  int         checks = 0;
  int         failures = 0;

  instr_imm_packer_if u_if ();

  instr_imm_packer #(.MEM_ADDR_WIDTH(8), .COUNT_WIDTH(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .base_addr   (base_addr),
    .in_if       (u_if.slave),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .err_code    (err_code),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_we", 32'(mem_addr), 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check_eq("wr_addr", 32'(mem_addr), 32'(e.addr));
        check_eq("wr_data", 32'(mem_wdata), 32'(e.data));
      end
      mem[mem_addr] = mem_wdata;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] base);
    start     = 1'b1;
    base_addr = base;
    tick();
    start     = 1'b0;
    exp_addr  = base;
  endtask

  // Offers one instruction; npush of the packed bytes are expected on the bus.
  task automatic send(input logic [2:0] src, input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] imm, input logic last,
                      input logic [31:0] exp_word, input int npush);
    int n;
    logic [31:0] w;
    n = 0;
    while (u_if.in_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check_eq("accept_wait", 32'(n < 20), 32'd1);
    w = exp_word;
    for (int i = 0; i < npush; i++) begin
      exp_q.push_back({exp_addr, w[7:0]});
      w = w >> 8;
      exp_addr = exp_addr + 8'd1;
    end
    u_if.ImmSrc = src; u_if.opcode = op; u_if.rd = rd; u_if.rs1 = rs1;
    u_if.rs2 = rs2; u_if.funct3 = f3; u_if.funct7 = f7; u_if.imm = imm;
    u_if.in_last = last;
    u_if.in_valid = 1'b1;
    tick();
    u_if.in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    u_if.in_valid = 1'b0; u_if.in_last = 1'b0; u_if.opcode = '0; u_if.rd = '0;
    u_if.rs1 = '0; u_if.rs2 = '0; u_if.funct3 = '0; u_if.funct7 = '0;
    u_if.ImmSrc = '0; u_if.imm = '0;

    repeat (3) tick();
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_ready", 32'(u_if.in_ready), 32'd0);
    check_eq("rst_we", 32'(mem_we), 32'd0);
    check_eq("rst_err", {29'd0, err, err_code}, 32'd0);
    check_eq("rst_count", 32'(instr_count), 32'd0);
    rst = 1'b1;
    tick();

    // Session 1: addi then beq, with latency and done checks
    do_start(8'h10);
    check_eq("start_busy", 32'(busy), 32'd1);
    send(3'b000, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 1'b0, 32'hFFF0_0093, 4);
    for (int i = 0; i < 4; i++) begin
      check_eq("ready_low", 32'(u_if.in_ready), 32'd0);
      tick();
    end
    check_eq("ready_back", 32'(u_if.in_ready), 32'd1);
    send(3'b010, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC, 1'b1, 32'hFE00_0EE3, 4);
    repeat (3) tick();
    check_eq("done_early", 32'(done), 32'd0);
    tick();
    check_eq("done_pulse", 32'(done), 32'd1);
    check_eq("count_2", 32'(instr_count), 32'd2);
    check_eq("idle_busy", 32'(busy), 32'd0);
    tick();
    check_eq("done_clear", 32'(done), 32'd0);

    // Session 2: sw, add, jal back-to-back
    do_start(8'h30);
    send(3'b001, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 1'b0, 32'h0020_A423, 4);
    send(3'b101, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'hDEAD_BEEF, 1'b0, 32'h0020_81B3, 4);
    send(3'b100, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 1'b1, 32'h0080_00EF, 4);
    repeat (4) tick();
    check_eq("done_s2", 32'(done), 32'd1);
    check_eq("count_3", 32'(instr_count), 32'd3);

    // Illegal immediates: range error, then misalign priority over range
    do_start(8'h20);
    send(3'b000, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b0, 32'd0, 0);
    check_eq("range_err", 32'(err), 32'd1);
    check_eq("range_code", 32'(err_code), 32'd1);
    check_eq("err_busy", 32'(busy), 32'd0);
    tick();
    check_eq("err_ready", 32'(u_if.in_ready), 32'd0);
    check_eq("err_sticky", 32'(err), 32'd1);
    do_start(8'h20);
    check_eq("restart_err", 32'(err), 32'd0);
    check_eq("restart_busy", 32'(busy), 32'd1);
    send(3'b100, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 1'b0, 32'd0, 0);
    check_eq("mis_code", 32'(err_code), 32'd2);

    // Address wrap with lui
    do_start(8'hFE);
    send(3'b011, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 1'b1, 32'h1234_52B7, 4);
    repeat (4) tick();
    check_eq("wrap_done", 32'(done), 32'd1);
    check_eq("wrap_mem01", 32'(mem[1]), 32'h12);

    // Reset landing on the edge that writes the second byte
    do_start(8'h40);
    send(3'b000, 7'h13, 5'd5, 5'd2, 5'd0, 3'd0, 7'd0, 32'h0000_0123, 1'b0, 32'h1231_0293, 2);
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check_eq("mrst_we", 32'(mem_we), 32'd0);
    check_eq("mrst_addr", 32'(mem_addr), 32'd0);
    check_eq("mrst_busy", 32'(busy), 32'd0);
    check_eq("mrst_count", 32'(instr_count), 32'd0);
    u_if.in_valid = 1'b1;
    repeat (5) tick();
    check_eq("mrst_ignored", 32'(u_if.in_ready), 32'd0);
    u_if.in_valid = 1'b0;
    check_eq("mrst_byte1", 32'(mem[8'h41]), 32'h02);
    check_eq("mrst_byte2", 32'(mem[8'h42]), 32'h00);
    check_eq("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
